// File: rtl/fetch_decode_pkg.sv
// -----------------------------------------------------------------------------
// fetch_decode_pkg
// Shared types and constants for the fetch/decode stage: FSM state encoding,
// supported opcodes, the HALT instruction word, operation_type codes and
// error codes reported on the error output.
// -----------------------------------------------------------------------------
package fetch_decode_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    DECODE,
    ISSUE,
    WAIT_DONE,
    HALT
  } state_t;

  localparam logic [6:0]  OP_R_ADD  = 7'b0110011;
  localparam logic [6:0]  OP_I_ADDI = 7'b0010011;
  localparam logic [31:0] HALT_WORD = 32'h0000_0073;

  localparam logic [1:0] OPTYPE_R = 2'd0;
  localparam logic [1:0] OPTYPE_I = 2'd1;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/fetch_decode_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_decode_unit_if
// Bundles every non-clock/reset signal of the fetch/decode stage.
//   master : the fetch/decode unit (drives imem_addr, issue fields, status)
//   slave  : the environment (instruction memory, execution controller, run)
// Signals:
//   run, imem_addr/imem_rdata, start, operation_type, source_1/2_address,
//   destination_address, source_immediate_value, pc, exec_busy,
//   fetch_stage_enable, next_pc, halted, error, retired_count
// -----------------------------------------------------------------------------
interface fetch_decode_unit_if #(
  parameter int PC_W = 5
);
  logic            run;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            start;
  logic [1:0]      operation_type;
  logic [4:0]      source_1_address;
  logic [4:0]      source_2_address;
  logic [4:0]      destination_address;
  logic [31:0]     source_immediate_value;
  logic [PC_W-1:0] pc;
  logic            exec_busy;
  logic            fetch_stage_enable;
  logic [PC_W-1:0] next_pc;
  logic            halted;
  logic [1:0]      error;
  logic [15:0]     retired_count;

  modport master (
    input  run, imem_rdata, exec_busy, fetch_stage_enable, next_pc,
    output imem_addr, start, operation_type, source_1_address,
           source_2_address, destination_address, source_immediate_value,
           pc, halted, error, retired_count
  );

  modport slave (
    output run, imem_rdata, exec_busy, fetch_stage_enable, next_pc,
    input  imem_addr, start, operation_type, source_1_address,
           source_2_address, destination_address, source_immediate_value,
           pc, halted, error, retired_count
  );
endinterface

// File: rtl/fetch_decode_unit_instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Purely combinational field extraction and legality check for add / addi.
// Ports:
//   instr    in  32  latched instruction word
//   is_halt  out 1   instr is the HALT word
//   is_legal out 1   instr is a supported add or addi
//   op_type  out 2   OPTYPE_R / OPTYPE_I
//   rs1, rs2, rd out 5  register addresses (rs2 zero for addi)
//   imm      out 32  addi immediate placed in the upper 12 bits (zero for add)
// -----------------------------------------------------------------------------
module instr_decoder
  import fetch_decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_halt,
  output logic        is_legal,
  output logic [1:0]  op_type,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm
);

  logic is_r;
  logic is_i;

  always_comb begin
    is_halt  = (instr == HALT_WORD);
    is_r     = (instr[6:0] == OP_R_ADD) && (instr[14:12] == 3'b000) &&
               (instr[31:25] == 7'b0000000);
    is_i     = (instr[6:0] == OP_I_ADDI) && (instr[14:12] == 3'b000);
    is_legal = is_r || is_i;
    op_type  = is_i ? OPTYPE_I : OPTYPE_R;
    rs1      = instr[19:15];
    rd       = instr[11:7];
    rs2      = is_r ? instr[24:20] : 5'd0;
    // raw 12-bit immediate lands on the sign/exponent/top-mantissa bits of a single
    imm      = is_i ? {instr[31:20], 20'b0} : 32'd0;
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// -----------------------------------------------------------------------------
// fetch_decode_unit
// Instruction fetch/decode stage in front of the add/addi execution controller.
// Holds the PC, reads a synchronous instruction memory, decodes add/addi,
// issues start, waits for the completion pulse, then fetches from next_pc.
// Halts on the HALT word, an illegal encoding or an issue timeout.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   bus  fetch_decode_unit_if.master (memory, issue fields, handshake, status)
// Optional build macro FETCH_DECODE_PERF_EN: enables the retired-instruction
// counter and an internal stall counter (stall_q); when undefined
// retired_count is tied to zero and no counter flops exist.
//
// state     | meaning
// IDLE      | parked, waiting for run
// FETCH     | memory read in flight
// LATCH     | capture imem_rdata into instr
// DECODE    | decode instr, load field outputs
// ISSUE     | start held high, waiting for exec_busy
// WAIT_DONE | waiting for fetch_stage_enable
// HALT      | terminal until reset
// -----------------------------------------------------------------------------
module fetch_decode_unit
  import fetch_decode_pkg::*;
#(
  parameter int PC_W          = 5,
  parameter int BOOT_PC       = 0,
  parameter int ISSUE_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_decode_unit_if.master   bus
);

  localparam int TMR_W = $clog2(ISSUE_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]       instr_q, instr_d;
  logic              start_q, start_d;
  logic [1:0]        op_q, op_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       imm_q, imm_d;
  logic [1:0]        error_q, error_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  logic              dec_halt;
  logic              dec_legal;
  logic [1:0]        dec_op;
  logic [4:0]        dec_rs1, dec_rs2, dec_rd;
  logic [31:0]       dec_imm;

  instr_decoder u_dec (
    .instr    (instr_q),
    .is_halt  (dec_halt),
    .is_legal (dec_legal),
    .op_type  (dec_op),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .imm      (dec_imm)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    imem_addr_d = imem_addr_q;
    instr_d     = instr_q;
    start_d     = start_q;
    op_d        = op_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    error_d     = error_q;
    tmr_d       = tmr_q;

    case (state_q)
      IDLE: begin
        if (bus.run) begin
          imem_addr_d = pc_q;
          state_d     = FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        instr_d = bus.imem_rdata;
        state_d = DECODE;
      end
      DECODE: begin
        if (dec_halt) begin
          state_d = HALT;
        end else if (dec_legal) begin
          op_d    = dec_op;
          rs1_d   = dec_rs1;
          rs2_d   = dec_rs2;
          rd_d    = dec_rd;
          imm_d   = dec_imm;
          start_d = 1'b1;
          tmr_d   = TMR_W'(ISSUE_TIMEOUT);
          state_d = ISSUE;
        end else begin
          error_d = ERR_ILLEGAL;
          state_d = HALT;
        end
      end
      ISSUE: begin
        // exec_busy is checked first so it wins over a same-cycle expiry
        if (bus.exec_busy) begin
          start_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (tmr_q <= TMR_W'(1)) begin
          start_d = 1'b0;
          error_d = ERR_TIMEOUT;
          state_d = HALT;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.fetch_stage_enable) begin
          pc_d        = bus.next_pc;
          imem_addr_d = bus.next_pc;
          state_d     = bus.run ? FETCH : IDLE;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= PC_W'(BOOT_PC);
      imem_addr_q <= PC_W'(BOOT_PC);
      instr_q     <= '0;
      start_q     <= 1'b0;
      op_q        <= OPTYPE_R;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      error_q     <= ERR_NONE;
      tmr_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_addr_q <= imem_addr_d;
      instr_q     <= instr_d;
      start_q     <= start_d;
      op_q        <= op_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      error_q     <= error_d;
      tmr_q       <= tmr_d;
    end
  end

`ifdef FETCH_DECODE_PERF_EN
  logic [15:0] retired_q, retired_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if ((state_q == WAIT_DONE) && bus.fetch_stage_enable && (retired_q != 16'hFFFF))
      retired_d = retired_q + 16'd1;
    if (((state_q == ISSUE) || (state_q == WAIT_DONE)) && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.retired_count = retired_q;
`else
  assign bus.retired_count = 16'd0;
`endif

  assign bus.imem_addr              = imem_addr_q;
  assign bus.start                  = start_q;
  assign bus.operation_type         = op_q;
  assign bus.source_1_address       = rs1_q;
  assign bus.source_2_address       = rs2_q;
  assign bus.destination_address    = rd_q;
  assign bus.source_immediate_value = imm_q;
  assign bus.pc                     = pc_q;
  assign bus.halted                 = (state_q == HALT);
  assign bus.error                  = error_q;

endmodule
